// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer.
// Uses a shift-add multiplier and a restoring shift-subtract divider that share
// one 2*XLEN accumulator, and returns to IDLE after a valid/ready handshake.
// Optional build macro MULDIV_FASTPATH_EN: trivial cases (divide-by-zero,
// signed overflow, zero multiply operand, |dividend| < |divisor|) skip CALC/FIX
// and finish directly at the accept edge.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;     // result sign differs (product / quotient)
  logic              sgn1_q, sgn1_d;   // dividend sign, drives remainder sign
  logic              div0_q, div0_d;
  logic              ovf_q, ovf_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;     // multiplicand (mul) or divisor (div) magnitude
  logic [XLEN-1:0]   raw_q, raw_d;     // raw rs1 for div-by-zero / overflow results
  logic [XLEN-1:0]   res_q, res_d;
  logic [2*XLEN-1:0] acc_q, acc_d;     // mul: {hi, multiplier}; div: {rem, quot}

  // Accept-edge operand decode: signedness per funct3, magnitudes, special cases.
  logic            s1_in, s2_in, div0_in, ovf_in;
  logic [XLEN-1:0] mag1, mag2;
  always_comb begin
    s1_in   = rs1[XLEN-1] & (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
    s2_in   = rs2[XLEN-1] & (op == 3'b001 || op == 3'b100 || op == 3'b110);
    mag1    = s1_in ? -rs1 : rs1;
    mag2    = s2_in ? -rs2 : rs2;
    div0_in = op[2] & (rs2 == '0);
    ovf_in  = op[2] & ~op[0] & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2);
  end

`ifdef MULDIV_FASTPATH_EN
  // Early-out detection; results match what the full iteration would produce.
  logic            fast_in;
  logic [XLEN-1:0] fast_res;
  always_comb begin
    fast_in  = 1'b0;
    fast_res = '0;
    if (op[2]) begin
      if (div0_in) begin
        fast_in = 1'b1; fast_res = op[1] ? rs1 : '1;
      end else if (ovf_in) begin
        fast_in = 1'b1; fast_res = op[1] ? '0 : rs1;
      end else if (mag1 < mag2) begin
        fast_in = 1'b1; fast_res = op[1] ? rs1 : '0;
      end
    end else if (mag1 == '0 || mag2 == '0) begin
      fast_in = 1'b1;
    end
  end
`endif

  // One iteration step for each datapath; only one is committed per op.
  logic [XLEN:0]     sum, sh;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] acc_mul, acc_div;
  always_comb begin
    sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    acc_mul = {sum, acc_q[XLEN-1:1]};
    sh      = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff    = {1'b0, sh} - {2'b00, dvs_q};
    // No borrow implies the difference is below the divisor, so bit XLEN is 0.
    acc_div = (diff[XLEN+1:XLEN] == 2'b00) ? {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                                           : {sh[XLEN-1:0],   acc_q[XLEN-2:0], 1'b0};
  end

  // Sign fix-up and result selection; special cases override the arithmetic.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;
  always_comb begin
    prod_fix = neg_q  ? -acc_q : acc_q;
    quot_fix = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = sgn1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = div0_q ? '1 : (ovf_q ? raw_q : quot_fix);
      default:                fix_res = div0_q ? raw_q : (ovf_q ? '0 : rem_fix);
    endcase
  end

  // Sequencer next-state: IDLE -> CALC (XLEN cycles) -> FIX -> DONE; flush wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    sgn1_d  = sgn1_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
    dvs_d   = dvs_q;
    raw_d   = raw_q;
    acc_d   = acc_q;
    res_d   = res_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_d    = op;
          neg_d   = s1_in ^ s2_in;
          sgn1_d  = s1_in;
          div0_d  = div0_in;
          ovf_d   = ovf_in;
          raw_d   = rs1;
          dvs_d   = op[2] ? mag2 : mag1;
          acc_d   = {{XLEN{1'b0}}, (op[2] ? mag1 : mag2)};
          cnt_d   = CNT_W'(XLEN-1);
          state_d = CALC;
`ifdef MULDIV_FASTPATH_EN
          if (fast_in) begin
            res_d   = fast_res;
            state_d = DONE;
          end
`endif
        end
        CALC: begin
          acc_d = op_q[2] ? acc_div : acc_mul;
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        FIX: begin
          res_d   = fix_res;
          state_d = DONE;
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers; async reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      sgn1_q  <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dvs_q   <= '0;
      raw_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      sgn1_q  <= sgn1_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
      dvs_q   <= dvs_d;
      raw_q   <= raw_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res       = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: the driver pushes hand-computed results,
// and a monitor pops/compares on every out_valid & out_ready handshake.
module tb_muldiv_seq;
  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 2;
`ifdef MULDIV_FASTPATH_EN
  localparam int SP_LAT = 1;
`else
  localparam int SP_LAT = XLEN + 2;
`endif

  typedef struct {
    string           nm;
    logic [XLEN-1:0] v;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, out_ready;
  logic            in_ready, out_valid, busy;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1, rs2, res;
  int              total = 0;
  int              bad = 0;
  exp_t            sbq[$];

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .busy(busy)
  );

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got=%h want=none", res);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk(e.nm, res, e.v);
      end
    end
  end

  // Issue one op, push its expectation and measure the observation edge of out_valid.
  task automatic do_op(input string nm, input logic [2:0] o, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] e, input int exp_lat);
    int edges;
    bit seen;
    @(negedge clk);
    chk({nm, "_in_ready"}, XLEN'(in_ready), 1);
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    sbq.push_back('{nm, e});
    @(posedge clk);
    #1 in_valid = 1'b0;
    op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    edges = 0; seen = 1'b0;
    while (!seen && edges < 200) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        edges++;
      end
    end
    chk({nm, "_seen"}, XLEN'(seen), 1);
    if (exp_lat > 0) chk({nm, "_lat"}, XLEN'(edges + 1), XLEN'(exp_lat));
    if (out_ready) @(posedge clk);
  endtask

  // Start an op with no expectation (it will be aborted).
  task automatic start_raw(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    int nout;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  XLEN'(in_ready), 1);
    chk("rst_out_valid", XLEN'(out_valid), 0);
    chk("rst_busy",      XLEN'(busy), 0);
    chk("rst_res",       res, 0);
    rst = 1'b0;

    do_op("div_m7_2",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT);
    do_op("rem_m7_2",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT);
    do_op("remu_7_2",  3'b111, 32'd7,         32'd2, 32'd1,         LAT);
    do_op("divu_z",    3'b101, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, SP_LAT);
    do_op("remu_z",    3'b111, 32'h1234_5678, 32'd0, 32'h1234_5678, SP_LAT);
    do_op("rem_z",     3'b110, 32'h1234_5678, 32'd0, 32'h1234_5678, SP_LAT);
    do_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SP_LAT);
    do_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, SP_LAT);
    do_op("mulh_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT);
    do_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT);
    do_op("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT);
    do_op("mul_max",   3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, LAT);

    // Backpressure: result held in DONE while out_ready is low.
    @(negedge clk) out_ready = 1'b0;
    do_op("bp_divu", 3'b101, 32'd100, 32'd7, 32'd14, LAT);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", XLEN'(out_valid), 1);
      chk("bp_res",       res, 32'd14);
      chk("bp_in_ready",  XLEN'(in_ready), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    do_op("bp_next_remu", 3'b111, 32'd100, 32'd7, 32'd2, LAT);

    // Flush in CALC cycle 5: back to IDLE, no result, res unchanged.
    start_raw(3'b101, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("fl_in_ready",  XLEN'(in_ready), 1);
    chk("fl_busy",      XLEN'(busy), 0);
    chk("fl_out_valid", XLEN'(out_valid), 0);
    chk("fl_res_kept",  res, 32'd2);
    nout = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) nout++;
    end
    chk("fl_no_out", XLEN'(nout), 0);

    // flush beats in_valid in IDLE.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = 3'b000; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    chk("fl_idle_busy", XLEN'(busy), 0);

    // Async reset mid-CALC, then a normal op.
    start_raw(3'b000, 32'd77, 32'd55);
    repeat (7) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("mr_in_ready",  XLEN'(in_ready), 1);
    chk("mr_busy",      XLEN'(busy), 0);
    chk("mr_out_valid", XLEN'(out_valid), 0);
    chk("mr_res",       res, 0);
    @(negedge clk) rst = 1'b0;
    do_op("mul_3_5", 3'b000, 32'd3, 32'd5, 32'd15, LAT);

    repeat (5) @(negedge clk);
    chk("sb_empty", XLEN'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "timeout");
  end

endmodule
